// File: rtl/btn_debounce_pulse.sv
// ============================================================================
// Module   : btn_debounce_pulse
// Brief    : Four-channel button synchroniser, debouncer and press-pulse generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned CNT_W           = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_out,
  output logic pressed_out
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic             REL_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             pressed_q;
  logic             pressed_d;
  logic             p;
  logic             cnt_done;

  assign p        = ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign cnt_done = (cnt_q == CNT_LAST);

  // Synchroniser resets to the released level so a held button is seen fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= REL_LEVEL;
      sync2_q <= REL_LEVEL;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      pressed_q <= pressed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (p) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!p) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!p) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (p) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Pressed level is registered from the next state so it rises with the pulse.
    pressed_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

  assign pulse_out   = pulse_q;
  assign pressed_out = pressed_q;

endmodule

module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_0_in,
  input  logic       btn_1_in,
  input  logic       btn_2_in,
  input  logic       btn_3_in,
  output logic       pulse_0_out,
  output logic       pulse_1_out,
  output logic       pulse_2_out,
  output logic       pulse_3_out,
  output logic [3:0] pressed_out
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [3:0] btn_vec;
  logic [3:0] pulse_vec;
  logic [3:0] pressed_vec;

  assign btn_vec = {btn_3_in, btn_2_in, btn_1_in, btn_0_in};

  for (genvar k = 0; k < 4; k++) begin : g_ch
    btn_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_vec[k]),
      .pulse_out   (pulse_vec[k]),
      .pressed_out (pressed_vec[k])
    );
  end

  assign pulse_0_out = pulse_vec[0];
  assign pulse_1_out = pulse_vec[1];
  assign pulse_2_out = pulse_vec[2];
  assign pulse_3_out = pulse_vec[3];
  assign pressed_out = pressed_vec;

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_pulse.sv
// ============================================================================
// Module   : tb_btn_debounce_pulse
// Brief    : Scoreboard bench for btn_debounce_pulse with DEBOUNCE_CYCLES = 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce_pulse;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] pulse;
  logic [3:0] pressed;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t sb[$];

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_0_in    (btn[0]),
    .btn_1_in    (btn[1]),
    .btn_2_in    (btn[2]),
    .btn_3_in    (btn[3]),
    .pulse_0_out (pulse[0]),
    .pulse_1_out (pulse[1]),
    .pulse_2_out (pulse[2]),
    .pulse_3_out (pulse[3]),
    .pressed_out (pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int ch, input int c);
    exp_t e;
    e.ch  = ch;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check_pressed(input string name, input logic [3:0] exp);
    checks++;
    if (pressed !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d pressed_out got %b expected %b", name, cyc, pressed, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every observed pulse must match the oldest expected entry for its channel.
  int idx;
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (pulse[k] === 1'b1) begin
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].ch == k) idx = i;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL pulse_extra: channel %0d pulsed at cycle %0d, none expected", k, cyc);
        end else begin
          if (sb[idx].cyc != cyc) begin
            errors++;
            $display("FAIL pulse_time: channel %0d pulsed at cycle %0d expected cycle %0d",
                     k, cyc, sb[idx].cyc);
          end
          sb.delete(idx);
        end
      end else if (pulse[k] !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL pulse_x: channel %0d value %b at cycle %0d expected 0 or 1", k, pulse[k], cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 20000", cyc);
    $fatal(1, "timeout");
  end

  int t;
  int pat[5] = '{0, 0, 0, 1, 0};

  initial begin
    rst = 1'b1;
    btn = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      check_pressed("reset_pressed", 4'b0000);
      @(negedge clk);
    end

    // Clean press and release on channel 0
    t = cyc;
    btn[0] = 1'b0;
    push_exp(0, t + 7);
    wait_until(t + 6);
    check_pressed("clean_before", 4'b0000);
    wait_until(t + 7);
    check_pressed("clean_rise", 4'b0001);
    wait_until(t + 20);
    check_pressed("clean_hold", 4'b0001);
    btn[0] = 1'b1;
    wait_until(t + 26);
    check_pressed("clean_rel_before", 4'b0001);
    wait_until(t + 27);
    check_pressed("clean_rel_fall", 4'b0000);
    wait_until(t + 32);

    // Bouncy press on channel 1
    for (int i = 0; i < 5; i++) begin
      btn[1] = pat[i][0];
      if (i == 4) begin
        t = cyc;
        push_exp(1, t + 7);
      end
      @(negedge clk);
    end
    wait_until(t + 12);
    check_pressed("bounce_pressed", 4'b0010);
    btn[1] = 1'b1;
    wait_until(t + 22);
    check_pressed("bounce_release", 4'b0000);

    // Short press glitch on channel 2 is rejected
    btn[2] = 1'b0;
    repeat (3) @(negedge clk);
    btn[2] = 1'b1;
    repeat (10) @(negedge clk);
    check_pressed("glitch_press", 4'b0000);

    // Held press on channel 2 with a 2-cycle release glitch
    t = cyc;
    btn[2] = 1'b0;
    push_exp(2, t + 7);
    wait_until(t + 10);
    btn[2] = 1'b1;
    repeat (2) @(negedge clk);
    btn[2] = 1'b0;
    repeat (10) begin
      check_pressed("glitch_release_hold", 4'b0100);
      @(negedge clk);
    end
    btn[2] = 1'b1;
    repeat (10) @(negedge clk);
    check_pressed("glitch_release_done", 4'b0000);

    // Simultaneous presses on all channels
    t = cyc;
    btn = 4'h0;
    for (int k = 0; k < 4; k++) push_exp(k, t + 7);
    wait_until(t + 8);
    check_pressed("simul_pressed", 4'b1111);
    btn = 4'hF;
    repeat (10) @(negedge clk);
    check_pressed("simul_release", 4'b0000);

    // Reset in the middle of a channel 3 debounce, button held throughout
    t = cyc;
    btn[3] = 1'b0;
    wait_until(t + 4);
    rst = 1'b1;
    wait_until(t + 5);
    rst = 1'b0;
    check_pressed("midrst_cleared", 4'b0000);
    push_exp(3, t + 12);
    wait_until(t + 12);
    check_pressed("midrst_rise", 4'b1000);
    wait_until(t + 14);
    check_pressed("midrst_hold", 4'b1000);
    btn[3] = 1'b1;
    repeat (10) @(negedge clk);
    check_pressed("midrst_release", 4'b0000);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pulse_missing: %0d expected pulses not seen, first channel %0d at cycle %0d",
               sb.size(), sb[0].ch, sb[0].cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/btn_debounce_pulse.md
# btn_debounce_pulse

Four-channel button conditioner that sits directly upstream of the pulse-counting adder. It synchronises each raw Poncho push-button input, debounces it with a per-channel state machine, and emits exactly one single-cycle pulse per confirmed press. The four pulse outputs wire one-to-one into the adder's button inputs, so one physical press adds exactly 1 to that channel's count.

## Interface
- DEBOUNCE_CYCLES, 240000, consecutive stable samples needed to confirm a press or a release; 20 ms at 12 MHz; legal range ≥ 2.
- ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width; derived, not overridden.
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- btn_0_in … btn_3_in  in  1 each  raw asynchronous button levels.
- pulse_0_out … pulse_3_out  out  1 each  registered one-cycle press pulse per channel.
- pressed_out  out  4  debounced pressed level; bit k is channel k.

## Operation
- Per channel: a 2-flop synchroniser feeds a normalised level p. p = ~sync when ACTIVE_LOW = 1, otherwise p = sync. p = 1 means pressed.
- Per channel: an independent FSM plus a CNT_W-bit counter. No state is shared between channels.
- IDLE: pressed = 0.
  - p = 1 → PRESS_WAIT, cnt ← 0.
- PRESS_WAIT:
  - p = 0 → IDLE, cnt ← 0.
  - p = 1 and cnt = DEBOUNCE_CYCLES−1 → PRESSED and pulse ← 1.
  - p = 1 otherwise → cnt ← cnt+1.
- PRESSED: pressed = 1.
  - p = 0 → RELEASE_WAIT, cnt ← 0.
- RELEASE_WAIT: pressed stays 1.
  - p = 1 → PRESSED, cnt ← 0, no pulse.
  - p = 0 and cnt = DEBOUNCE_CYCLES−1 → IDLE.
  - p = 0 otherwise → cnt ← cnt+1.
- pulse_k_out is set only on the edge that moves PRESS_WAIT → PRESSED. It clears on the following edge.
- Exactly one pulse per press, whatever the bounce on press or release.
- Counter never wraps: it is compared against DEBOUNCE_CYCLES−1 and cleared on every state change.
- Simultaneous presses on several channels that confirm on the same edge give pulses in the same cycle. The downstream adder absorbs them in one cycle.
- Reset (synchronous, rst = 1 at an edge):
  - Synchroniser flops are loaded with the released level, so p = 0.
  - FSMs go to IDLE and counters to 0.
  - All pulse_k_out = 0 and pressed_out = 4'b0000.
  - Takes priority over every transition.
- Reset mid-operation: an in-progress PRESS_WAIT is abandoned with no pulse, and a PRESSED channel drops pressed immediately.
- Button held through reset release: it is treated as a fresh press and produces one pulse after full latency.

## Timing
- Edges are numbered from E0, the first edge sampling a raw pressed level that then stays stable.
- E1: p = 1.
- E2: IDLE → PRESS_WAIT.
- E(DEBOUNCE_CYCLES+2): → PRESSED.
- pulse_k_out is high for the single cycle between E(D+2) and E(D+3).
- pressed bit k rises with the same edge as the pulse.
- Release latency is symmetric: pressed bit k falls at E(D+2) counted from the first sampled released level.
- A p glitch lasting fewer than D+1 samples while in IDLE produces no pulse and no pressed change.
- A release glitch lasting fewer than D samples while in PRESSED produces no pressed change.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
Run with DEBOUNCE_CYCLES = 4 and ACTIVE_LOW = 1.
- Reset: all btn_k_in = 1, rst high for 2 cycles → every pulse_k_out = 0 and pressed_out = 0000, held until a press.
- Clean press: btn_0_in = 0 from E0, held 20 cycles → pulse_0_out high only between E6 and E7, pressed_out = 0001 from E6. Release at E20 → pressed_out = 0000 at E26. Other channels stay 0.
- Press bounce: btn_1_in pattern 0,0,0,1,0 then held 0 → exactly one pulse_1_out, 6 edges after the last 1→0 transition is sampled.
- Glitch rejection: btn_2_in low 3 cycles then high → no pulse_2_out, pressed_out[2] stays 0. Same channel pressed, then a 2-cycle release glitch, then held → pressed_out[2] stays 1 and no second pulse.
- Simultaneous presses: all four btn_k_in go low on the same edge → all four pulses high in the same cycle. When feeding the adder, every count_k_out increments by 1.
- Reset mid-debounce: rst asserted at E4 of a btn_3_in press and released at E5, button still held → no pulse at E6. One pulse follows 6 edges after the post-reset synchroniser sees the press.
